// File: rtl/hc595_pkg.sv
// Shared constants and state encoding for the 74HC595 chain driver.
package hc595_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned FRAME_EDGES = 34;
  localparam int unsigned LATCH_EDGE  = 32;
  localparam int unsigned EDGE_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

endpackage

// File: rtl/hc595_driver_tick_gen.sv
// Free-running divider: one-Clk tick every CLK_DIV cycles, for slow-peripheral drivers.
module tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] div_q, div_d;

  assign tick = (div_q == CntW'(CLK_DIV - 1));

  always_comb begin
    div_d = div_q + CntW'(1);
    if (tick) div_d = '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

endmodule

// File: rtl/hc595_driver.sv
// Shifts {Seg, Sel} MSB first into a two-chip 74HC595 chain and latches it, frame after frame.
module hc595_driver
  import hc595_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       En,
  input  logic [7:0] Seg,
  input  logic [7:0] Sel,
  output logic       DS,
  output logic       SH_CP,
  output logic       ST_CP,
  output logic       Frame_done,
  output logic       Busy
);

  logic tick;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .tick   (tick)
  );

  state_e              state_q, state_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                ds_q, ds_d;
  logic                sh_q, sh_d;
  logic                st_q, st_d;
  logic                done_q, done_d;
  logic [3:0]          bit_idx;

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    word_d  = word_q;
    ds_d    = ds_q;
    sh_d    = sh_q;
    st_d    = st_q;
    done_d  = 1'b0;
    bit_idx = 4'd0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (En) begin
            state_d = SHIFT;
            edge_d  = '0;
            word_d  = {Seg, Sel};
            ds_d    = Seg[7];
            sh_d    = 1'b0;
            st_d    = 1'b0;
          end
        end
        SHIFT: begin
          edge_d = edge_q + EDGE_W'(1);
          if (edge_d == EDGE_W'(LATCH_EDGE)) begin
            state_d = LATCH;
            sh_d    = 1'b0;
            st_d    = 1'b1;
          end else if (edge_d[0]) begin
            sh_d = 1'b1;
          end else begin
            // Even edge 2i presents word bit 15-i.
            sh_d    = 1'b0;
            bit_idx = 4'(5'(WORD_W - 1) - edge_d[5:1]);
            ds_d    = word_q[bit_idx];
          end
        end
        LATCH: begin
          if (edge_q == EDGE_W'(LATCH_EDGE)) begin
            edge_d = EDGE_W'(FRAME_EDGES - 1);
            st_d   = 1'b0;
            done_d = 1'b1;
          end else if (En) begin
            // Back-to-back frame: this tick is already edge 0.
            state_d = SHIFT;
            edge_d  = '0;
            word_d  = {Seg, Sel};
            ds_d    = Seg[7];
            sh_d    = 1'b0;
            st_d    = 1'b0;
          end else begin
            state_d = IDLE;
            edge_d  = '0;
            ds_d    = 1'b0;
            sh_d    = 1'b0;
            st_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      edge_q  <= '0;
      word_q  <= '0;
      ds_q    <= 1'b0;
      sh_q    <= 1'b0;
      st_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      word_q  <= word_d;
      ds_q    <= ds_d;
      sh_q    <= sh_d;
      st_q    <= st_d;
      done_q  <= done_d;
    end
  end

  assign DS         = ds_q;
  assign SH_CP      = sh_q;
  assign ST_CP      = st_q;
  assign Frame_done = done_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench for hc595_driver at CLK_DIV=2 and CLK_DIV=5.
module tb_hc595_driver;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       En = 1'b0;
  logic       En5 = 1'b0;
  logic [7:0] Seg = 8'h00;
  logic [7:0] Sel = 8'h00;
  logic       DS, SH_CP, ST_CP, Frame_done, Busy;
  logic       DS5, SH_CP5, ST_CP5, Frame_done5, Busy5;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  hc595_driver dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .En        (En),
    .Seg       (Seg),
    .Sel       (Sel),
    .DS        (DS),
    .SH_CP     (SH_CP),
    .ST_CP     (ST_CP),
    .Frame_done(Frame_done),
    .Busy      (Busy)
  );

  hc595_driver #(
    .CLK_DIV(5)
  ) dut5 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .En        (En5),
    .Seg       (Seg),
    .Sel       (Sel),
    .DS        (DS5),
    .SH_CP     (SH_CP5),
    .ST_CP     (ST_CP5),
    .Frame_done(Frame_done5),
    .Busy      (Busy5)
  );

  // Pin-level observers, sampled mid-cycle.
  int          cyc = 0;
  int          rise_cnt = 0, st_cnt = 0, done_cnt = 0, nz_cnt = 0;
  int          busy_rise_cyc = 0, done_cyc = 0;
  logic [15:0] bits = '0;
  logic        sh_prev = 0, st_prev = 0, busy_prev = 0;

  int          rise5 = 0, done5 = 0, bad_w5 = 0, busy_rise5 = 0, done_cyc5 = 0;
  int          rise_cyc5 = 0, fall_cyc5 = 0;
  logic        fall_valid5 = 0;
  logic [15:0] bits5 = '0;
  logic        sh_prev5 = 0, st_prev5 = 0, busy_prev5 = 0;

  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (SH_CP && !sh_prev) begin
      rise_cnt = rise_cnt + 1;
      bits = {bits[14:0], DS};
    end
    if (ST_CP && !st_prev) st_cnt = st_cnt + 1;
    if (Frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (Busy && !busy_prev) busy_rise_cyc = cyc;
    if (DS || SH_CP || ST_CP || Frame_done || Busy) nz_cnt = nz_cnt + 1;
    sh_prev = SH_CP;
    st_prev = ST_CP;
    busy_prev = Busy;

    if (SH_CP5 && !sh_prev5) begin
      rise5 = rise5 + 1;
      bits5 = {bits5[14:0], DS5};
      if (fall_valid5 && (cyc - fall_cyc5) != 5) bad_w5 = bad_w5 + 1;
      rise_cyc5 = cyc;
    end
    if (!SH_CP5 && sh_prev5) begin
      if ((cyc - rise_cyc5) != 5) bad_w5 = bad_w5 + 1;
      fall_cyc5 = cyc;
      fall_valid5 = 1'b1;
    end
    if (ST_CP5 && !st_prev5) fall_valid5 = 1'b0;
    if (Frame_done5) begin
      done5 = done5 + 1;
      done_cyc5 = cyc;
    end
    if (Busy5 && !busy_prev5) busy_rise5 = cyc;
    sh_prev5 = SH_CP5;
    st_prev5 = ST_CP5;
    busy_prev5 = Busy5;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  // Bounded waits; an expired budget shows up as a failed check.
  task automatic wait_rises(input int target, input string tag);
    int k = 0;
    while (rise_cnt < target && k < 400) begin
      step(1);
      k++;
    end
    chk(tag, int'(rise_cnt >= target), 1);
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (done_cnt < target && k < 400) begin
      step(1);
      k++;
    end
    chk(tag, int'(done_cnt >= target), 1);
  endtask

  int r0, s0, d0, n0, t1, b5, r5, d5;

  initial begin
    // Reset held, then released idle.
    step(5);
    chk("rst_ds", int'(DS), 0);
    chk("rst_sh", int'(SH_CP), 0);
    chk("rst_st", int'(ST_CP), 0);
    chk("rst_done", int'(Frame_done), 0);
    chk("rst_busy", int'(Busy), 0);
    Reset_n = 1'b1;
    n0 = nz_cnt;
    step(200);
    chk("idle_quiet", nz_cnt - n0, 0);

    // Single frame 3f/01.
    Seg = 8'h3f; Sel = 8'h01;
    r0 = rise_cnt; s0 = st_cnt; d0 = done_cnt;
    En = 1'b1;
    wait_done(d0 + 1, "f1_timeout");
    En = 1'b0;
    chk("f1_rises", rise_cnt - r0, 16);
    chk("f1_bits", int'(bits), 32'h3f01);
    chk("f1_latch", st_cnt - s0, 1);
    chk("f1_done_lat", done_cyc - busy_rise_cyc, 66);
    step(10);
    chk("f1_done_cnt", done_cnt - d0, 1);
    chk("f1_idle", int'(Busy), 0);

    // Continuous run, Seg changed mid-frame.
    r0 = rise_cnt; s0 = st_cnt; d0 = done_cnt;
    En = 1'b1;
    wait_rises(r0 + 5, "cont_rise_timeout");
    Seg = 8'h06;
    wait_done(d0 + 1, "cont1_timeout");
    chk("cont1_bits", int'(bits), 32'h3f01);
    t1 = done_cyc;
    wait_done(d0 + 2, "cont2_timeout");
    En = 1'b0;
    chk("cont2_bits", int'(bits), 32'h0601);
    chk("cont_period", done_cyc - t1, 68);
    chk("cont_latches", st_cnt - s0, 2);
    chk("cont_rises", rise_cnt - r0, 32);
    step(10);

    // En dropped at edge 5.
    Seg = 8'h5b; Sel = 8'h04;
    r0 = rise_cnt; s0 = st_cnt; d0 = done_cnt;
    En = 1'b1;
    wait_rises(r0 + 3, "drop_rise_timeout");
    En = 1'b0;
    wait_done(d0 + 1, "drop_timeout");
    chk("drop_bits", int'(bits), 32'h5b04);
    chk("drop_latch", st_cnt - s0, 1);
    step(40);
    chk("drop_busy", int'(Busy), 0);
    chk("drop_rises", rise_cnt - r0, 16);

    // Reset mid-frame near edge 20.
    Seg = 8'ha5; Sel = 8'h5a;
    r0 = rise_cnt; s0 = st_cnt;
    En = 1'b1;
    wait_rises(r0 + 10, "rstmid_timeout");
    step(2);
    Reset_n = 1'b0;
    #1;
    chk("rstmid_ds", int'(DS), 0);
    chk("rstmid_sh", int'(SH_CP), 0);
    chk("rstmid_st", int'(ST_CP), 0);
    chk("rstmid_busy", int'(Busy), 0);
    step(5);
    chk("rstmid_no_latch", st_cnt - s0, 0);
    r0 = rise_cnt; s0 = st_cnt; d0 = done_cnt;
    Reset_n = 1'b1;
    wait_done(d0 + 1, "fresh_timeout");
    En = 1'b0;
    chk("fresh_rises", rise_cnt - r0, 16);
    chk("fresh_bits", int'(bits), 32'ha55a);
    chk("fresh_latch", st_cnt - s0, 1);
    step(10);

    // CLK_DIV=5 instance.
    Seg = 8'hc3; Sel = 8'h81;
    b5 = bad_w5; r5 = rise5; d5 = done5;
    En5 = 1'b1;
    begin
      int k = 0;
      while (done5 < d5 + 1 && k < 800) begin step(1); k++; end
      chk("d5_f1_timeout", int'(done5 >= d5 + 1), 1);
    end
    chk("d5_bits", int'(bits5), 32'hc381);
    chk("d5_rises", rise5 - r5, 16);
    chk("d5_done_lat", done_cyc5 - busy_rise5, 165);
    t1 = done_cyc5;
    begin
      int k = 0;
      while (done5 < d5 + 2 && k < 800) begin step(1); k++; end
      chk("d5_f2_timeout", int'(done5 >= d5 + 2), 1);
    end
    En5 = 1'b0;
    chk("d5_period", done_cyc5 - t1, 170);
    chk("d5_widths", bad_w5 - b5, 0);
    step(20);
    chk("d5_idle", int'(Busy5), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
